mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory + writeback pipeline stage; consumer of EX outputs (aluoutE, writedataE, writeregE).
//  Holds EX/MEM and MEM/WB registers and drives a variable-latency data-memory req/ack bus.
//  Feeds aluoutM / resultW back to the EX forwarding muxes.
//  Raises stallM while a load/store is outstanding.
// PARAMETERS
//  TIMEOUT  16             cycles dmem_req may wait for dmem_ack before abort (>=2)
//  TW       $clog2(TIMEOUT+1)  width of the wait counter
// PORTS
//  clk          in   1   core clock, rising edge
//  reset        in   1   asynchronous, active-high
//  regwriteE    in   1   EX op writes the register file
//  memtoregE    in   1   EX op is a load
//  memwriteE    in   1   EX op is a store
//  aluoutE      in   32  address or ALU result
//  writedataE   in   32  store data
//  writeregE    in   5   destination register
//  aluoutM      out  32  EX/MEM ALU result (forward path)
//  writeregM    out  5   EX/MEM destination (to hazard unit)
//  regwriteM    out  1   EX/MEM regwrite (to hazard unit)
//  stallM       out  1   freeze IF..EX and EX/MEM; bubble into MEM/WB
//  resultW      out  32  writeback data (forward path and register file)
//  writeregW    out  5   writeback destination
//  regwriteW    out  1   writeback enable
//  dmem_req     out  1   memory request valid
//  dmem_we      out  1   1 = store, 0 = load
//  dmem_addr    out  32  word address = aluoutM; bits [1:0] are always 0 when req=1
//  dmem_wdata   out  32  = writedataM
//  dmem_ack     in   1   one-cycle completion pulse; rdata valid in the same cycle
//  dmem_rdata   in   32  load data
//  bus_err      out  1   sticky flag: timeout seen
//  misalign     out  1   sticky flag: mem op with aluoutM[1:0] != 0
// BEHAVIOUR
//  Reset (async):
//   - All registered outputs go to 0; FSM enters IDLE; wait counter = 0.
//  EX/MEM register:
//   - Loads all EX inputs on a clk edge when stallM = 0; holds them when stallM = 1.
//  memopM definition:
//   - memopM = memtoregM | memwriteM. Both set is illegal and is treated as a load.
//  FSM, IDLE:
//   - If memopM = 1 and the address is aligned: dmem_req = 1 combinationally, counter cleared, state -> BUSY.
//  FSM, BUSY:
//   - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack.
//   - Counter increments every cycle without ack.
//  Ack:
//   - dmem_ack = 1 in IDLE-issue or BUSY completes the op in that cycle; state -> IDLE.
//   - Ack arriving in the issue cycle = zero-wait access.
//  stallM:
//   - stallM = memopM & aligned & ~dmem_ack & ~timeout_hit. This is a combinational ack->stall path.
//  Timeout:
//   - Counter reaching TIMEOUT-1 without ack sets timeout_hit for one cycle.
//   - The op completes, regwriteW is forced 0 and bus_err is set.
//   - A late ack in IDLE is ignored.
//  Misaligned access:
//   - Mem op with aluoutM[1:0] != 0: no dmem_req, no stall, regwriteW forced 0, misalign set.
//  MEM/WB register, stallM = 0:
//   - regwriteW <= regwriteM & (writeregM != 0) & ~abort, where abort = timeout or misalign.
//   - writeregW <= writeregM.
//   - resultW <= memtoregM ? dmem_rdata : aluoutM.
//  MEM/WB register, stallM = 1:
//   - Bubble: regwriteW <= 0; resultW and writeregW hold.
//  Latency:
//   - Non-memory ops reach W one cycle after M.
//   - A load with ack in wait cycle k (0 = issue cycle) stalls k cycles.
//  Back-to-back memory ops:
//   - The next op issues in the cycle after the previous ack; no idle gap is required.
//  Reset mid-BUSY:
//   - Drops dmem_req immediately (async); any in-flight ack after reset is ignored.
// STRUCTURE
//  core_pkg:
//   - typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t.
//   - localparam REG_ZERO = 5'd0.
//  Sub-module dmem_req_fsm:
//   - Contains the state register, wait counter, stall/abort logic and bus drive.
//   - The pipeline registers stay in mem_wb_stage.
// TESTING
//  1. ALU op aluoutE=0x1234, writeregE=5, regwriteE=1 -> next cycle aluoutM=0x1234;
//     following cycle resultW=0x1234, writeregW=5, regwriteW=1, stallM never 1.
//  2. Load addr 0x40, ack after 3 wait cycles with rdata=0xCAFEF00D ->
//     stallM=1 for 3 cycles, dmem_addr stable at 0x40,
//     then resultW=0xCAFEF00D, regwriteW=1.
//  3. Store addr 0x80, data 0xA5A5A5A5, ack in issue cycle ->
//     dmem_we=1, dmem_wdata=0xA5A5A5A5, stallM=0 throughout, regwriteW=0.
//  4. Load with no ack, TIMEOUT=16 -> stallM high for 15 cycles, then drops;
//     bus_err=1, regwriteW=0; a later ack is ignored.
//  5. Load addr 0x41 -> dmem_req never asserted, misalign=1, regwriteW=0, no stall.
//  6. Assert reset during BUSY -> dmem_req and all outputs 0 before the next clk edge;
//     after reset release, an ALU op flows normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the memory/writeback pipeline slice.
package core_pkg;

    typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer: issue/wait state, wait counter, stall and abort
// decisions, bus strobes and the sticky error flags.
module dmem_req_fsm
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic memopM,
    input  logic loadM,
    input  logic alignedM,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic dmem_we,
    output logic stallM,
    output logic abortM,
    output logic bus_err,
    output logic misalign
);

    mem_state_t    state, state_next;
    logic [TW-1:0] cnt, cnt_next;
    logic          issue;
    logic          timeout_hit;
    logic          misaligned_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MEM_IDLE;
            cnt      <= '0;
            bus_err  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (timeout_hit)
                bus_err <= 1'b1;
            if (misaligned_op)
                misalign <= 1'b1;
        end
    end

    // cnt holds the index of the current wait cycle; the issue cycle is wait cycle 0.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        timeout_hit   = 1'b0;
        issue         = memopM & alignedM;
        misaligned_op = memopM & ~alignedM;
        dmem_req      = issue;
        dmem_we       = issue & ~loadM;

        case (state)
            MEM_IDLE: begin
                cnt_next = '0;
                if (issue && !dmem_ack) begin
                    state_next = MEM_BUSY;
                    cnt_next   = TW'(1);
                end
            end
            MEM_BUSY: begin
                if (dmem_ack) begin
                    state_next = MEM_IDLE;
                    cnt_next   = '0;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = MEM_IDLE;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = MEM_IDLE;
                cnt_next   = '0;
            end
        endcase

        stallM = issue & ~dmem_ack & ~timeout_hit;
        abortM = misaligned_op | timeout_hit;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory + writeback stage: EX/MEM and MEM/WB registers around a variable-latency
// req/ack data-memory port, with forward paths and a pipeline stall output.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        memwriteE,
    input  logic [31:0] aluoutE,
    input  logic [31:0] writedataE,
    input  logic [4:0]  writeregE,
    output logic [31:0] aluoutM,
    output logic [4:0]  writeregM,
    output logic        regwriteM,
    output logic        stallM,
    output logic [31:0] resultW,
    output logic [4:0]  writeregW,
    output logic        regwriteW,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        bus_err,
    output logic        misalign
);

    logic        memtoregM;
    logic        memwriteM;
    logic [31:0] writedataM;
    logic        abortM;

    // ---- EX/MEM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
            aluoutM    <= '0;
            writedataM <= '0;
            writeregM  <= REG_ZERO;
        end else if (!stallM) begin
            regwriteM  <= regwriteE;
            memtoregM  <= memtoregE;
            memwriteM  <= memwriteE;
            aluoutM    <= aluoutE;
            writedataM <= writedataE;
            writeregM  <= writeregE;
        end
    end

    // A load+store combination is handled as a load, so memtoregM alone selects the direction.
    dmem_req_fsm #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_dmem_req_fsm (
        .clk      (clk),
        .reset    (reset),
        .memopM   (memtoregM | memwriteM),
        .loadM    (memtoregM),
        .alignedM (word_aligned(aluoutM)),
        .dmem_ack (dmem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .stallM   (stallM),
        .abortM   (abortM),
        .bus_err  (bus_err),
        .misalign (misalign)
    );

    assign dmem_addr  = aluoutM;
    assign dmem_wdata = writedataM;

    // ---- MEM/WB ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwriteW <= 1'b0;
            writeregW <= REG_ZERO;
            resultW   <= '0;
        end else if (stallM) begin
            regwriteW <= 1'b0;
        end else begin
            regwriteW <= regwriteM & (writeregM != REG_ZERO) & ~abortM;
            writeregW <= writeregM;
            resultW   <= memtoregM ? dmem_rdata : aluoutM;
        end
    end

endmodule
